// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM encoding,
// button index map and a counter-width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int NUM_BTNS  = 4;
    localparam int BTN_CLEAR = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_START = 3;

    // Keeps counters at least one bit wide when a parameter is set to 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stable-level debounce and a
// single-cycle press pulse on the debounced released->pressed edge.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 80000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          pressed;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    assign pressed = ~sync_q[1];

    // The counter only runs while the synced input disagrees with the
    // debounced level, so any bounce back to the old level restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (pressed != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= {sync_q[0], btn_n_i};
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, IDLE/RUN/PAUSE FSM,
// free-running tick divider and lap-display hold timer; all outputs registered.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 800000,
    parameter int DEBOUNCE_CYCLES = 80000,
    parameter int LAP_HOLD_TICKS  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    output logic       count_en,
    output logic       count_clr,
    output logic       lap_capture,
    output logic       show_lap,
    output logic       running,
    output logic [1:0] state
);

    localparam int            DW        = cnt_width(TICK_DIV);
    localparam int            HW        = cnt_width(LAP_HOLD_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(LAP_HOLD_TICKS);

    logic [NUM_BTNS-1:0] press;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_n_i(btn_n[i]),
            .press_o(press[i])
        );
    end

    logic          ev_clear, ev_stop, ev_start, ev_lap;
    logic          tick;
    logic          lap_act;
    logic [DW-1:0] div_q, div_d;
    sw_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          count_en_q, count_en_d;
    logic          count_clr_q, count_clr_d;
    logic          lap_capture_q, lap_capture_d;
    logic          show_lap_q, show_lap_d;
    logic          running_q, running_d;

    // Only the highest-priority press is acted on in a given cycle.
    assign ev_clear = press[BTN_CLEAR];
    assign ev_stop  = press[BTN_STOP]  & ~ev_clear;
    assign ev_start = press[BTN_START] & ~ev_clear & ~press[BTN_STOP];
    assign ev_lap   = press[BTN_LAP]   & ~ev_clear & ~press[BTN_STOP] & ~press[BTN_START];

    assign tick    = (div_q == DIV_LAST);
    assign div_d   = tick ? '0 : div_q + 1'b1;
    assign lap_act = ev_lap && (state_q == RUN || state_q == PAUSE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ev_clear) begin
            state_d = IDLE;
        end else if (ev_stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (ev_start) begin
            if (state_q == IDLE || state_q == PAUSE) state_d = RUN;
        end
        if (state_d != IDLE && state_d != RUN && state_d != PAUSE) state_d = IDLE;
    end

    // A lap winning the cycle still lets a coincident tick advance the count.
    always_comb begin
        count_en_d    = tick && (state_q == RUN) && !ev_clear && !ev_stop;
        count_clr_d   = ev_clear;
        lap_capture_d = lap_act;
        hold_d        = hold_q;
        if (ev_clear) begin
            hold_d = '0;
        end else if (lap_act) begin
            hold_d = HOLD_LOAD;
        end else if (tick && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
        show_lap_d = (hold_d != '0);
        running_d  = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q        <= '0;
            count_en_q    <= 1'b0;
            count_clr_q   <= 1'b0;
            lap_capture_q <= 1'b0;
            show_lap_q    <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            count_en_q    <= count_en_d;
            count_clr_q   <= count_clr_d;
            lap_capture_q <= lap_capture_d;
            show_lap_q    <= show_lap_d;
            running_q     <= running_d;
        end
    end

    assign count_en    = count_en_q;
    assign count_clr   = count_clr_q;
    assign lap_capture = lap_capture_q;
    assign show_lap    = show_lap_q;
    assign running     = running_q;
    assign state       = state_q;

endmodule
